// File: rtl/udp_packet_parser.sv
// udp_packet_parser
//   Receive-side UDP parser for the gigabit Ethernet MAC wrapper. Takes the
//   byte stream from the MAC RX FIFO (FCS already stripped) and parses the
//   Ethernet II / IPv4 (no options) / UDP headers. The UDP payload is
//   forwarded only when the frame is addressed to the local MAC/IP/port.
//   For accepted packets the sender's addresses are captured. Accept and
//   drop counters are kept for software.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   slave_*                frame byte stream in (valid/ready/last)
//   rx_streaming_*         UDP payload byte stream out (valid/ready/last)
//   localMac/Ip/Port       local addressing; broadcast MAC is also accepted
//   rxSrcMac/Ip/Port       sender of the last accepted packet
//   pktGoodCount           accepted packets (wraps)
//   pktDropCount           rejected, runt and header-truncated frames (wraps)
//   pktTruncated           one-cycle pulse when a frame ends before its UDP
//                          length is satisfied
//
// Handshake: a byte moves on a port in any cycle where valid && ready are
// both high at the rising clock edge. valid never depends on ready. In
// PAYLOAD the input and output are wired straight through, so
// slave_ready == rx_streaming_ready and rx_streaming_valid == slave_valid.
module udp_packet_parser #(
    parameter int HDR_BYTES = 42,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           slave_data,
    input  logic                 slave_valid,
    input  logic                 slave_last,
    output logic                 slave_ready,
    output logic [7:0]           rx_streaming_data,
    output logic                 rx_streaming_valid,
    output logic                 rx_streaming_last,
    input  logic                 rx_streaming_ready,
    input  logic [47:0]          localMac,
    input  logic [31:0]          localIp,
    input  logic [15:0]          localPort,
    output logic [47:0]          rxSrcMac,
    output logic [31:0]          rxSrcIp,
    output logic [15:0]          rxSrcPort,
    output logic [CNT_WIDTH-1:0] pktGoodCount,
    output logic [CNT_WIDTH-1:0] pktDropCount,
    output logic                 pktTruncated
);

    localparam logic [1:0] ST_HEADER  = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    localparam logic [5:0]           LAST_HDR_IDX = 6'(HDR_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    // Destination MAC is tracked with two flags because a frame may match
    // either the local MAC or broadcast, but not a byte-wise mix of the two.
    logic                 mac_eq_q, mac_eq_d;
    logic                 bcast_q, bcast_d;
    logic                 match_q, match_d;
    logic [47:0]          src_mac_sh_q, src_mac_sh_d;
    logic [31:0]          src_ip_sh_q, src_ip_sh_d;
    logic [15:0]          src_port_sh_q, src_port_sh_d;
    logic [15:0]          udp_len_q, udp_len_d;
    logic [15:0]          remaining_q, remaining_d;
    logic [47:0]          rx_src_mac_q, rx_src_mac_d;
    logic [31:0]          rx_src_ip_q, rx_src_ip_d;
    logic [15:0]          rx_src_port_q, rx_src_port_d;
    logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 trunc_q, trunc_d;

    // Expected byte for the header position currently being received.
    logic [7:0] mac_byte;
    logic [7:0] exp_byte;
    logic       chk_en;
    logic       accept;

    always_comb begin
        mac_byte = 8'h00;
        exp_byte = 8'h00;
        chk_en   = 1'b0;
        case (idx_q)
            6'd0:  mac_byte = localMac[47:40];
            6'd1:  mac_byte = localMac[39:32];
            6'd2:  mac_byte = localMac[31:24];
            6'd3:  mac_byte = localMac[23:16];
            6'd4:  mac_byte = localMac[15:8];
            6'd5:  mac_byte = localMac[7:0];
            6'd12: begin chk_en = 1'b1; exp_byte = 8'h08;            end
            6'd13: begin chk_en = 1'b1; exp_byte = 8'h00;            end
            6'd14: begin chk_en = 1'b1; exp_byte = 8'h45;            end
            6'd23: begin chk_en = 1'b1; exp_byte = 8'h11;            end
            6'd30: begin chk_en = 1'b1; exp_byte = localIp[31:24];   end
            6'd31: begin chk_en = 1'b1; exp_byte = localIp[23:16];   end
            6'd32: begin chk_en = 1'b1; exp_byte = localIp[15:8];    end
            6'd33: begin chk_en = 1'b1; exp_byte = localIp[7:0];     end
            6'd36: begin chk_en = 1'b1; exp_byte = localPort[15:8];  end
            6'd37: begin chk_en = 1'b1; exp_byte = localPort[7:0];   end
            default: ;
        endcase
    end

    // All checked fields end by byte 37 and the UDP length by byte 39, so
    // the registered flags are final when byte 41 arrives.
    assign accept = (mac_eq_q || bcast_q) && match_q && (udp_len_q > 16'd8);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mac_eq_d      = mac_eq_q;
        bcast_d       = bcast_q;
        match_d       = match_q;
        src_mac_sh_d  = src_mac_sh_q;
        src_ip_sh_d   = src_ip_sh_q;
        src_port_sh_d = src_port_sh_q;
        udp_len_d     = udp_len_q;
        remaining_d   = remaining_q;
        rx_src_mac_d  = rx_src_mac_q;
        rx_src_ip_d   = rx_src_ip_q;
        rx_src_port_d = rx_src_port_q;
        good_cnt_d    = good_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        trunc_d       = 1'b0;

        case (state_q)
            ST_HEADER: begin
                if (slave_valid) begin
                    if (idx_q <= 6'd5) begin
                        if (slave_data != mac_byte) mac_eq_d = 1'b0;
                        if (slave_data != 8'hff)    bcast_d  = 1'b0;
                    end
                    if (chk_en && (slave_data != exp_byte)) match_d = 1'b0;

                    // Fields arrive big-endian on consecutive indices, so a
                    // left shift assembles each one in place.
                    if (idx_q >= 6'd6 && idx_q <= 6'd11)
                        src_mac_sh_d = {src_mac_sh_q[39:0], slave_data};
                    if (idx_q >= 6'd26 && idx_q <= 6'd29)
                        src_ip_sh_d = {src_ip_sh_q[23:0], slave_data};
                    if (idx_q >= 6'd34 && idx_q <= 6'd35)
                        src_port_sh_d = {src_port_sh_q[7:0], slave_data};
                    if (idx_q >= 6'd38 && idx_q <= 6'd39)
                        udp_len_d = {udp_len_q[7:0], slave_data};

                    if (idx_q == LAST_HDR_IDX) begin
                        idx_d    = 6'd0;
                        mac_eq_d = 1'b1;
                        bcast_d  = 1'b1;
                        match_d  = 1'b1;
                        if (accept) begin
                            rx_src_mac_d  = src_mac_sh_q;
                            rx_src_ip_d   = src_ip_sh_q;
                            rx_src_port_d = src_port_sh_q;
                            good_cnt_d    = good_cnt_q + CNT_ONE;
                            remaining_d   = udp_len_q - 16'd8;
                            if (slave_last) begin
                                // Header complete but no payload at all.
                                trunc_d    = 1'b1;
                                drop_cnt_d = drop_cnt_q + CNT_ONE;
                                state_d    = ST_HEADER;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end else begin
                            drop_cnt_d = drop_cnt_q + CNT_ONE;
                            state_d    = slave_last ? ST_HEADER : ST_DROP;
                        end
                    end else if (slave_last) begin
                        // Runt: frame ended inside the header.
                        drop_cnt_d = drop_cnt_q + CNT_ONE;
                        idx_d      = 6'd0;
                        mac_eq_d   = 1'b1;
                        bcast_d    = 1'b1;
                        match_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (slave_valid && rx_streaming_ready) begin
                    remaining_d = remaining_q - 16'd1;
                    if (slave_last) begin
                        if (remaining_q > 16'd1) trunc_d = 1'b1;
                        state_d = ST_HEADER;
                    end else if (remaining_q == 16'd1) begin
                        // UDP payload done; the rest is Ethernet padding.
                        state_d = ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                if (slave_valid && slave_last) state_d = ST_HEADER;
            end

            default: state_d = ST_HEADER;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_HEADER;
            idx_q         <= 6'd0;
            mac_eq_q      <= 1'b1;
            bcast_q       <= 1'b1;
            match_q       <= 1'b1;
            src_mac_sh_q  <= 48'd0;
            src_ip_sh_q   <= 32'd0;
            src_port_sh_q <= 16'd0;
            udp_len_q     <= 16'd0;
            remaining_q   <= 16'd0;
            rx_src_mac_q  <= 48'd0;
            rx_src_ip_q   <= 32'd0;
            rx_src_port_q <= 16'd0;
            good_cnt_q    <= '0;
            drop_cnt_q    <= '0;
            trunc_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mac_eq_q      <= mac_eq_d;
            bcast_q       <= bcast_d;
            match_q       <= match_d;
            src_mac_sh_q  <= src_mac_sh_d;
            src_ip_sh_q   <= src_ip_sh_d;
            src_port_sh_q <= src_port_sh_d;
            udp_len_q     <= udp_len_d;
            remaining_q   <= remaining_d;
            rx_src_mac_q  <= rx_src_mac_d;
            rx_src_ip_q   <= rx_src_ip_d;
            rx_src_port_q <= rx_src_port_d;
            good_cnt_q    <= good_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            trunc_q       <= trunc_d;
        end
    end

    assign slave_ready        = (state_q == ST_PAYLOAD) ? rx_streaming_ready : 1'b1;
    assign rx_streaming_data  = slave_data;
    assign rx_streaming_valid = (state_q == ST_PAYLOAD) && slave_valid;
    assign rx_streaming_last  = (state_q == ST_PAYLOAD) &&
                                ((remaining_q == 16'd1) || slave_last);

    assign rxSrcMac     = rx_src_mac_q;
    assign rxSrcIp      = rx_src_ip_q;
    assign rxSrcPort    = rx_src_port_q;
    assign pktGoodCount = good_cnt_q;
    assign pktDropCount = drop_cnt_q;
    assign pktTruncated = trunc_q;

endmodule

// File: doc/udp_packet_parser.md
# udp_packet_parser

Receive-side counterpart of the UDP packet builder in the gigabit Ethernet MAC wrapper. Consumes the 8-bit frame stream delivered by the MAC RX FIFO (FCS already stripped), parses the Ethernet II / IPv4 / UDP headers, and forwards the UDP payload only for frames addressed to the local MAC/IP/port. Captures the sender's addresses and maintains accept/drop counters for software visibility.

## Interface
Parameters:
- HDR_BYTES, 42, fixed header length (14 Ethernet + 20 IPv4 with no options + 8 UDP)
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  reset, asynchronous and active-low
- slave_data  in  8  frame byte from the MAC RX FIFO
- slave_valid  in  1  byte valid
- slave_last  in  1  final byte of the frame
- slave_ready  out  1  parser accepts byte
- rx_streaming_data  out  8  UDP payload byte
- rx_streaming_valid  out  1  payload byte valid
- rx_streaming_last  out  1  final payload byte
- rx_streaming_ready  in  1  downstream accepts byte
- localMac  in  48  accepted destination MAC; ff:ff:ff:ff:ff:ff is also accepted
- localIp  in  32  accepted destination IP
- localPort  in  16  accepted destination UDP port
- rxSrcMac  out  48  source MAC of the last accepted packet
- rxSrcIp  out  32  source IP of the last accepted packet
- rxSrcPort  out  16  source UDP port of the last accepted packet
- pktGoodCount  out  CNT_WIDTH  number of accepted packets, wraps
- pktDropCount  out  CNT_WIDTH  number of rejected or runt frames, wraps
- pktTruncated  out  1  one-cycle pulse when a frame ends before its UDP length is satisfied

## Operation
- Byte transfer means valid && ready. A 6-bit byte index counts header transfers 0..41.
- FSM states are HEADER, PAYLOAD and DROP. The reset state is HEADER with index 0.
- HEADER state:
  - slave_ready=1.
  - Checks made on the fly, each clearing a sticky match flag on mismatch:
    - bytes 0-5 equal localMac or are all 0xff;
    - bytes 12-13 are 0x0800;
    - byte 14 is 0x45;
    - byte 23 is 0x11;
    - bytes 30-33 equal localIp;
    - bytes 36-37 equal localPort.
  - Staged into shadow registers: bytes 6-11 (source MAC), 26-29 (source IP), 34-35 (source port), 38-39 (UDP length, big-endian).
- Decision on the transfer of byte 41. The packet is accepted when match=1 and UDP length > 8.
  - Accept: rxSrc* are loaded from the shadow registers, pktGoodCount increments, and a 16-bit remaining counter is loaded with UDP length − 8.
    - Next state is PAYLOAD if slave_last=0.
    - If slave_last=1 on byte 41, the packet is treated as truncated: pktTruncated pulses, pktDropCount increments, and the FSM returns to HEADER.
  - Reject: pktDropCount increments. Next state is DROP, or HEADER if slave_last=1.
- slave_last on any header byte before byte 41 is a runt frame: pktDropCount increments, the FSM returns to HEADER and the index clears.
- PAYLOAD state:
  - Combinational pass-through: rx_streaming_data=slave_data, rx_streaming_valid=slave_valid, slave_ready=rx_streaming_ready.
  - Each transfer decrements remaining.
  - rx_streaming_last=1 when remaining==1 or slave_last=1.
  - When remaining==1 and slave_last=0, the next state is DROP, which discards Ethernet padding.
  - When slave_last=1 and remaining>1, pktTruncated pulses and the next state is HEADER.
  - When slave_last=1 and remaining==1, the next state is HEADER.
- DROP state: slave_ready=1 and no output. On slave_last, the FSM moves to HEADER.
- rx_streaming_valid=0 in every state other than PAYLOAD.
- Counters and rxSrc* update only at the events above. Counters wrap at 2^CNT_WIDTH.
- Config inputs are sampled live. Software changes them only while idle.

## Timing
- Payload latency is 0 cycles (combinational data/valid/ready path). All state, the counters and rxSrc* update on the rising clk edge.
- rxSrc* and pktGoodCount are visible in the cycle after the byte-41 transfer.
- The first payload byte can be offered in the cycle after the byte-41 transfer.
- While rx_streaming_ready=0 in PAYLOAD, slave_ready=0 and all state holds. No byte is lost or duplicated.
- slave_valid=0 in any state: no state change.
- Reset state while resetn=0 (asynchronous assert, synchronous release):
  - FSM in HEADER, index 0, match flag = 1;
  - all counters, rxSrc* and pktTruncated = 0;
  - slave_ready = 1, rx_streaming_valid = 0.
- Reset asserted mid-frame: the frame is abandoned, and parsing restarts at the next byte after release (treated as byte 0).

## Test plan
- Valid frame, localMac=02:00:00:00:00:01, localIp=192.168.1.10, localPort=4660, UDP length 24, 16-byte payload 0x00..0x0f -> 16 output bytes 0x00..0x0f, last on 0x0f, pktGoodCount=1, rxSrcPort equals the frame's source port; padding to the 60-byte minimum consumed silently.
- Same frame with dst port 4661, then with protocol 0x06, then with ethertype 0x0806 -> no output, pktDropCount=3.
- Broadcast destination MAC with matching IP/port and an 8-byte payload -> accepted, 8 bytes out.
- Random rx_streaming_ready (50% duty) over a 1000-byte payload -> output byte sequence identical to the input, no drops.
- 30-byte runt frame, then a UDP length of 100 with the frame ending after 20 payload bytes -> runt adds 1 to pktDropCount; the truncated packet forwards 20 bytes with last on byte 20 and pulses pktTruncated once.
- resetn pulsed low during a payload byte -> outputs return to their reset values immediately; the next full valid frame is parsed correctly.
